// File: rtl/dot_acc_if.sv
// Product-in / frame-result-out handshake bundle for dot_acc.
// The slave modport is the accumulator side.
interface dot_acc_if #(
  parameter int PW = 6,
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] p;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic          ovf;

  modport master (
    output in_valid, p, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, p, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/dot_acc.sv
// Frame accumulator behind the 3-bit multiplier: sums LEN products,
// then holds the frame sum and sticky carry flag until taken.
module dot_acc #(
  parameter int PW  = 6,
  parameter int LEN = 4,
  parameter int AW  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr,
  dot_acc_if.slave bus,
  output logic     busy
);
  localparam int CW = $clog2(LEN);
  localparam int SW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [AW-1:0] sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_acc_q, ovf_acc_d;
  logic          ovf_q, ovf_d;
  logic          in_ready;
  logic          accept;
  logic          last;
  logic [AW:0]   add;

  // clr masks in_ready so an abort never swallows a product
  assign in_ready = (state_q == ACC) && !clr;
  assign accept   = bus.in_valid && in_ready;
  assign last     = (cnt_q == LAST);
  assign add      = {1'b0, acc_q} + SW'(bus.p);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign busy          = (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    unique case (1'b1)
      clr: begin
        state_d   = ACC;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
      end
      accept && last: begin
        sum_d     = add[AW-1:0];
        ovf_d     = ovf_acc_q | add[AW];
        acc_d     = '0;
        cnt_d     = '0;
        ovf_acc_d = 1'b0;
        state_d   = HOLD;
      end
      accept && !last: begin
        acc_d     = add[AW-1:0];
        ovf_acc_d = ovf_acc_q | add[AW];
        cnt_d     = cnt_q + 1'b1;
      end
      !clr && state_q == HOLD && bus.out_ready: begin
        state_d = ACC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_dot_acc.sv
// Bench for dot_acc: AW=8 and AW=7 instances in lockstep, table frames,
// hand-written corner sequences and a scoreboard on the result port.
module tb_dot_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic busy8;
  logic busy7;

  dot_acc_if #(.PW(6), .AW(8)) b8 ();
  dot_acc_if #(.PW(6), .AW(7)) b7 ();

  assign b7.in_valid  = b8.in_valid;
  assign b7.p         = b8.p;
  assign b7.out_ready = b8.out_ready;

  dot_acc #(.PW(6), .LEN(4), .AW(8)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (b8.slave),
    .busy (busy8)
  );

  dot_acc #(.PW(6), .LEN(4), .AW(7)) u7 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (b7.slave),
    .busy (busy7)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] s8;
    logic       o8;
    logic [6:0] s7;
    logic       o7;
  } exp_t;

  typedef struct packed {
    logic [3:0][5:0] p;
    logic [7:0]      s8;
    logic            o8;
    logic [6:0]      s7;
    logic            o7;
  } vec_t;

  int   checks = 0;
  int   fails = 0;
  exp_t sbq[$];

  int         m_cnt = 0;
  logic [7:0] m8 = '0;
  logic       m_o8 = 1'b0;
  logic [6:0] m7 = '0;
  logic       m_o7 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m8 = '0;
    m_o8 = 1'b0;
    m7 = '0;
    m_o7 = 1'b0;
  endtask

  task automatic model_add(input int v);
    logic [8:0] t8;
    logic [7:0] t7;
    exp_t e;
    t8 = {1'b0, m8} + 9'(v);
    t7 = {1'b0, m7} + 8'(v);
    m_o8 = m_o8 | t8[8];
    m_o7 = m_o7 | t7[7];
    m8 = t8[7:0];
    m7 = t7[6:0];
    m_cnt++;
    if (m_cnt == 4) begin
      e.s8 = m8;
      e.o8 = m_o8;
      e.s7 = m7;
      e.o7 = m_o7;
      sbq.push_back(e);
      model_clear();
    end
  endtask

  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    b8.in_valid = 1'b1;
    b8.p = 6'(v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b8.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL send_timeout actual=0 required=1");
    end else begin
      @(posedge clk);
      #1;
      model_add(v);
    end
    b8.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b8.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL out_timeout actual=0 required=1");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() != 0; i++)
      @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
  endtask

  // scoreboard side: compare every result taken downstream
  always @(negedge clk) begin
    if (rst_n && b8.out_valid) begin
      chk("hold_in_ready", b8.in_ready, 0);
      if (b8.out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL sb_unexpected actual=%0d required=none",
                   b8.sum);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_sum8", b8.sum, e.s8);
          chk("sb_ovf8", b8.ovf, e.o8);
          chk("sb_sum7", b7.sum, e.s7);
          chk("sb_ovf7", b7.ovf, e.o7);
        end
      end
    end
  end

  vec_t tbl[6];

  initial begin
    tbl[0] = '{p: {6'd4, 6'd3, 6'd2, 6'd1},
               s8: 8'd10, o8: 1'b0, s7: 7'd10, o7: 1'b0};
    tbl[1] = '{p: {6'd49, 6'd49, 6'd49, 6'd49},
               s8: 8'd196, o8: 1'b0, s7: 7'd68, o7: 1'b1};
    tbl[2] = '{p: {6'd1, 6'd0, 6'd0, 6'd0},
               s8: 8'd1, o8: 1'b0, s7: 7'd1, o7: 1'b0};
    tbl[3] = '{p: {6'd63, 6'd63, 6'd63, 6'd63},
               s8: 8'd252, o8: 1'b0, s7: 7'd124, o7: 1'b1};
    tbl[4] = '{p: {6'd60, 6'd60, 6'd60, 6'd60},
               s8: 8'd240, o8: 1'b0, s7: 7'd112, o7: 1'b1};
    tbl[5] = '{p: {6'd0, 6'd63, 6'd63, 6'd63},
               s8: 8'd189, o8: 1'b0, s7: 7'd61, o7: 1'b1};

    b8.in_valid = 1'b0;
    b8.p = '0;
    b8.out_ready = 1'b1;
    #2;
    chk("rst_in_ready", b8.in_ready, 1);
    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_sum", b8.sum, 0);
    chk("rst_ovf", b8.ovf, 0);
    chk("rst_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1,2,3,4 back-to-back: busy trace and a single-cycle result
    for (int k = 1; k <= 3; k++) begin
      send(k);
      chk("t1_busy", busy8, 1);
    end
    send(4);
    chk("t1_busy_last", busy8, 0);
    chk("t1_valid", b8.out_valid, 1);
    chk("t1_sum", b8.sum, 10);
    @(posedge clk);
    #1;
    chk("t1_one_cycle", b8.out_valid, 0);

    // 49x4 with backpressure; product offered during HOLD is ignored
    b8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(49);
    b8.in_valid = 1'b1;
    b8.p = 6'd5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t2_valid", b8.out_valid, 1);
      chk("t2_ready", b8.in_ready, 0);
      chk("t2_sum8", b8.sum, 196);
      chk("t2_ovf8", b8.ovf, 0);
      chk("t2_sum7", b7.sum, 68);
      chk("t2_ovf7", b7.ovf, 1);
    end
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    b8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t2_exit_valid", b8.out_valid, 0);
    chk("t2_exit_ready", b8.in_ready, 1);
    for (int k = 0; k < 3; k++) send(0);
    send(1);
    chk("t3_sum7", b7.sum, 1);
    chk("t3_ovf7", b7.ovf, 0);
    @(posedge clk);
    #1;

    // clr aborts a partial frame and refuses the product beside it
    send(5);
    send(7);
    clr = 1'b1;
    b8.in_valid = 1'b1;
    b8.p = 6'd9;
    @(negedge clk);
    chk("t4_clr_ready", b8.in_ready, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    b8.in_valid = 1'b0;
    model_clear();
    chk("t4_busy", busy8, 0);
    for (int k = 0; k < 4; k++) send(2);
    chk("t4_sum", b8.sum, 8);
    @(posedge clk);
    #1;

    // clr while holding discards the result
    b8.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(k);
    wait_out();
    chk("t5_held", b8.sum, 10);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("t5_dropped", b8.out_valid, 0);
    if (sbq.size() != 0) void'(sbq.pop_front());
    b8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(1);
    chk("t5_sum", b8.sum, 4);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) send(int'(tbl[i].p[k]));
      wait_out();
      chk("tbl_sum8", b8.sum, tbl[i].s8);
      chk("tbl_ovf8", b8.ovf, tbl[i].o8);
      chk("tbl_sum7", b7.sum, tbl[i].s7);
      chk("tbl_ovf7", b7.ovf, tbl[i].o7);
      @(posedge clk);
      #1;
    end

    // exhaustive 3-bit product sweep with random gaps
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(a * b);
      end
    end
    drain();

    // async reset mid-frame
    send(3);
    send(4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", b8.in_ready, 1);
    chk("ar_out_valid", b8.out_valid, 0);
    chk("ar_sum", b8.sum, 0);
    chk("ar_ovf", b8.ovf, 0);
    chk("ar_busy", busy8, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(10);
    send(20);
    send(30);
    send(40);
    wait_out();
    chk("ar_next_sum", b8.sum, 100);
    @(posedge clk);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/dot_acc.md
# dot_acc

Sequential accumulator directly downstream of the 3-bit combinational multiplier `mul`. It consumes the 6-bit product `p` through a valid/ready handshake and sums exactly `LEN` products into one frame result, forming the accumulate half of a dot-product/MAC path. It presents each frame sum with an overflow flag on an output valid/ready handshake, then starts the next frame.

## Interface
- `PW`, 6, product width (matches `mul` output `p`).
- `LEN`, 4, products per frame; legal range 2..255.
- `AW`, 8, accumulator/sum width; must be ≥ `PW`.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `clr`  input  1  synchronous frame abort.
- `in_valid`  input  1  product available.
- `in_ready`  output  1  block accepts a product this cycle.
- `p`  input  `PW`  product from `mul`, unsigned.
- `out_valid`  output  1  frame result held.
- `out_ready`  input  1  downstream takes the result.
- `sum`  output  `AW`  frame sum, modulo 2^`AW`.
- `ovf`  output  1  frame sum exceeded 2^`AW`−1.
- `busy`  output  1  frame partially accumulated (count ≠ 0).

Clock and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- States:
  - ACC: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Internal registers:
  - `acc` is `AW` bits.
  - `cnt` counts 0..`LEN`−1.
  - `ovf_acc` is a sticky carry flag.
- Accept: `in_valid && in_ready` at a rising edge.
- ACC, accept, `cnt` < `LEN`−1:
  - `acc` ← `acc` + `p` (zero-extended, truncated to `AW`).
  - `ovf_acc` ← `ovf_acc` | carry-out.
  - `cnt` ← `cnt` + 1.
- ACC, accept, `cnt` = `LEN`−1 (last product):
  - `sum` ← `acc` + `p`.
  - `ovf` ← `ovf_acc` | carry-out.
  - `acc`, `cnt`, `ovf_acc` ← 0.
  - Go to HOLD.
- ACC with no accept: all registers hold.
- HOLD:
  - `sum` and `ovf` are stable.
  - On `out_ready`=1, go to ACC.
  - `sum`/`ovf` keep their last value after leaving HOLD; they are only meaningful while `out_valid`=1.
- `clr`=1 has priority over all events in any state:
  - `acc`, `cnt`, `ovf_acc` ← 0.
  - Go to ACC, so `out_valid` drops next cycle.
  - A product offered in the same cycle is not accepted: `in_ready` is driven 0 whenever `clr`=1.
  - A pending HOLD result is discarded.
- `busy` = (`cnt` ≠ 0).
- Arithmetic is unsigned. `sum` wraps modulo 2^`AW`. `ovf` is set if any partial addition in the frame carried out of bit `AW`−1.

## Timing
- Reset (async assert, sync release) values:
  - State = ACC.
  - `in_ready`=1, `out_valid`=0.
  - `sum`=0, `ovf`=0, `busy`=0.
  - `acc`=0, `cnt`=0.
- `in_ready`, `out_valid` and `busy` are Moore outputs of registered state, except that `in_ready` is also gated low combinationally by `clr`.
- Latency:
  - `out_valid` rises the cycle after the last product is accepted.
  - Minimum frame period is `LEN`+1 cycles with `out_ready` held high: `LEN` accepts plus one HOLD cycle.
- No overlap: no product is accepted while in HOLD, so backpressure from `out_ready` stalls the upstream.
- `in_valid` may drop between products; gaps do not affect the result.
- `p` is sampled only on accept.
- `out_ready` asserted while in ACC has no effect.
- Reset mid-frame discards the partial sum and any held result.

## Test plan
- Reset, then feed 1,2,3,4 back-to-back with `out_ready`=1 -> `out_valid` for exactly one cycle, one cycle after the 4th accept; `sum`=10, `ovf`=0; `busy` is 1 after accepts 1–3 and 0 after the 4th.
- Feed 49×4 with `out_ready`=0 for 5 cycles after the result -> `sum`=196, `ovf`=0 stable throughout HOLD; `in_ready`=0 during HOLD; the next frame starts the cycle after `out_ready`=1.
- Override `AW`=7, feed 49×4 -> `sum`=68 (196 mod 128), `ovf`=1; next frame 0,0,0,1 -> `sum`=1, `ovf`=0 (sticky flag cleared per frame).
- Feed 5,7 then assert `clr` together with `in_valid` and `p`=9 -> 9 not accepted, `busy`=0; then 2,2,2,2 -> `sum`=8.
- In HOLD holding `sum`=10, pulse `clr` -> `out_valid`=0 next cycle, result discarded; next frame 1,1,1,1 -> `sum`=4.
- Drive random `in_valid` gaps with products of an exhaustive a,b sweep (64 pairs = 16 frames) -> each `sum` equals the software sum of its 4 products; `rst_n` pulsed mid-frame async -> all outputs at reset values immediately, and the next frame's sum is correct.
